frame_buffer_dbl: RTL and testbench

Parametrised, double-buffered successor to the single 4-bit pixel buffer between the NiosII PIO writer and the VGA controller. Holds two frames of PIX_W-bit pixels:
- Writer always targets the back frame; VGA reads always come from the front frame.
- Front and back swap only at vertical-blank start, which gives tear-free updates.
- A hardware clear engine fills the back frame without processor writes.

---
 rtl/frame_buffer_dbl.sv | 162 ++++++++++++++++
 tb/tb_frame_buffer_dbl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_dbl.sv
// Double-buffered PIX_W-bit frame store between a PIO writer and a VGA reader, with a hardware clear engine.
// Optional build macro FB_OOR_COUNT_EN adds OOR_CNT, a saturating count of dropped out-of-range writes.
module frame_buffer_dbl #(
  parameter int                 PIX_W     = 4,
  parameter int                 ADDR_W    = 15,
  parameter int                 DEPTH     = 19200,
  parameter logic [PIX_W-1:0]   CLEAR_VAL = {PIX_W{1'b0}}
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [PIX_W-1:0]  WR_DATA,
  input  logic              WR_EN,
  output logic              WR_READY,
  input  logic              CLEAR_REQ,
  output logic              BUSY,
  input  logic              SWAP_REQ,
  input  logic              VSYNC_START,
  output logic              SWAP_PENDING,
  output logic              FRONT_SEL,
  input  logic [ADDR_W-1:0] RD_ADDR,
`ifdef FB_OOR_COUNT_EN
  output logic [15:0]       OOR_CNT,
`endif
  output logic [PIX_W-1:0]  RD_DATA
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam int              LP_WORDS = 2 ** (ADDR_W + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_busy;
  logic                r_wr_ready;
  logic                r_swap_pending;
  logic                r_front_sel;
  logic [PIX_W-1:0]    r_rd_data;
  logic [PIX_W-1:0]    r_mem [0:LP_WORDS-1];

  logic                w_wr_inrange;
  logic                w_rd_inrange;
  logic                w_wr_we;
  logic                w_clr_we;
  logic                w_mem_we;
  logic [ADDR_W:0]     w_mem_waddr;
  logic [PIX_W-1:0]    w_mem_wdata;
  logic                w_swap_now;
  logic                w_clr_last;

  assign w_wr_inrange = ({1'b0, WR_ADDR} < LP_DEPTH);
  assign w_rd_inrange = ({1'b0, RD_ADDR} < LP_DEPTH);
  assign w_clr_last   = ({1'b0, r_clr_addr} == LP_LAST);
  assign w_swap_now   = VSYNC_START & r_swap_pending & (r_state == ST_IDLE);

  // One shared write port: the clear engine owns it in CLEAR, the writer in IDLE.
  always_comb begin
    w_clr_we    = 1'b0;
    w_wr_we     = 1'b0;
    w_mem_waddr = {~r_front_sel, WR_ADDR};
    w_mem_wdata = WR_DATA;
    if (r_state == ST_CLEAR) begin
      w_clr_we    = 1'b1;
      w_mem_waddr = {~r_front_sel, r_clr_addr};
      w_mem_wdata = CLEAR_VAL;
    end else begin
      w_wr_we = WR_EN & w_wr_inrange;
    end
    w_mem_we = w_clr_we | w_wr_we;
  end

  always_ff @(posedge VGA_CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Front-frame read; FRONT_SEL is taken from the same cycle as RD_ADDR.
  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      r_rd_data <= CLEAR_VAL;
    end else if (w_rd_inrange) begin
      r_rd_data <= r_mem[{r_front_sel, RD_ADDR}];
    end else begin
      r_rd_data <= CLEAR_VAL;
    end
  end

  // Control FSM plus swap bookkeeping; swaps wait for IDLE so a fill never changes target.
  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= ST_IDLE;
      r_clr_addr     <= {ADDR_W{1'b0}};
      r_busy         <= 1'b0;
      r_wr_ready     <= 1'b1;
      r_swap_pending <= 1'b0;
      r_front_sel    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CLEAR_REQ) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= {ADDR_W{1'b0}};
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (w_clr_last) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= {ADDR_W{1'b0}};
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase

      if (w_swap_now) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= 1'b0;
      end else begin
        r_swap_pending <= r_swap_pending | SWAP_REQ;
      end
    end
  end

`ifdef FB_OOR_COUNT_EN
  logic [15:0] r_oor_cnt;

  // Saturating tally of writes dropped for being past the end of the frame.
  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      r_oor_cnt <= 16'h0000;
    end else if (WR_EN & r_wr_ready & ~w_wr_inrange & (r_oor_cnt != 16'hFFFF)) begin
      r_oor_cnt <= r_oor_cnt + 16'h0001;
    end else begin
      r_oor_cnt <= r_oor_cnt;
    end
  end

  assign OOR_CNT = r_oor_cnt;
`endif

  assign WR_READY     = r_wr_ready;
  assign BUSY         = r_busy;
  assign SWAP_PENDING = r_swap_pending;
  assign FRONT_SEL    = r_front_sel;
  assign RD_DATA      = r_rd_data;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Directed self-checking bench for frame_buffer_dbl (default parameters, 160x120 frame of 4-bit pixels).
module tb_frame_buffer_dbl;

  localparam int DEPTH = 19200;

  logic        clk;
  logic        rst;
  logic [14:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_en;
  logic        wr_ready;
  logic        clear_req;
  logic        busy;
  logic        swap_req;
  logic        vsync_start;
  logic        swap_pending;
  logic        front_sel;
  logic [14:0] rd_addr;
  logic [3:0]  rd_data;
`ifdef FB_OOR_COUNT_EN
  logic [15:0] oor_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  frame_buffer_dbl dut (
    .VGA_CLK      (clk),
    .RESET        (rst),
    .WR_ADDR      (wr_addr),
    .WR_DATA      (wr_data),
    .WR_EN        (wr_en),
    .WR_READY     (wr_ready),
    .CLEAR_REQ    (clear_req),
    .BUSY         (busy),
    .SWAP_REQ     (swap_req),
    .VSYNC_START  (vsync_start),
    .SWAP_PENDING (swap_pending),
    .FRONT_SEL    (front_sel),
    .RD_ADDR      (rd_addr),
`ifdef FB_OOR_COUNT_EN
    .OOR_CNT      (oor_cnt),
`endif
    .RD_DATA      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_clear(input bit sw_with, input int vs_at, input int wr_at,
                           output int nbusy, output int nnrdy);
    clear_req = 1'b1;
    swap_req  = sw_with;
    tick();
    clear_req = 1'b0;
    swap_req  = 1'b0;
    nbusy = 0;
    nnrdy = 0;
    while (busy === 1'b1 && nbusy < DEPTH + 10) begin
      nbusy++;
      if (wr_ready === 1'b0) nnrdy++;
      vsync_start = (nbusy == vs_at);
      if (nbusy == wr_at) begin
        wr_addr = 15'd3;
        wr_data = 4'hF;
        wr_en   = 1'b1;
      end
      tick();
      vsync_start = 1'b0;
      wr_en       = 1'b0;
    end
  endtask

  int nb;
  int nr;
  int bad;

  initial begin
    rst = 1'b1; wr_addr = 15'd0; wr_data = 4'h0; wr_en = 1'b0;
    clear_req = 1'b0; swap_req = 1'b0; vsync_start = 1'b0; rd_addr = 15'd0;
    tick();
    chk("rst_front", front_sel, 0);
    chk("rst_pend", swap_pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_rd", rd_data, 0);
`ifdef FB_OOR_COUNT_EN
    chk("rst_oor", oor_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Clear back frame 1 with a blocked write in the middle; expect exactly DEPTH busy cycles.
    run_clear(1'b0, -1, 50, nb, nr);
    chk("clr1_busy_len", nb, DEPTH);
    chk("clr1_notready_len", nr, DEPTH);
    chk("clr1_ready_after", wr_ready, 1);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    chk("swap1_front", front_sel, 1);
    chk("swap1_pend", swap_pending, 0);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = a[14:0];
      tick();
      if (rd_data !== 4'h0) bad++;
      if (a == 3) chk("clr1_addr3_blocked_wr", rd_data, 0);
    end
    chk("clr1_all_zero", bad, 0);

    // Clear frame 0 with simultaneous swap request; VSYNC mid-clear must not swap.
    run_clear(1'b1, 100, -1, nb, nr);
    chk("clr2_busy_len", nb, DEPTH);
    chk("clr2_front_held", front_sel, 1);
    chk("clr2_pend_held", swap_pending, 1);
    tick(); tick();
    chk("clr2_front_idle", front_sel, 1);
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    chk("clr2_front_swap", front_sel, 0);
    chk("clr2_pend_clr", swap_pending, 0);

    // Back-frame write is invisible until swap; read latency one cycle.
    wr_addr = 15'd5; wr_data = 4'hA; wr_en = 1'b1; tick(); wr_en = 1'b0;
    rd_addr = 15'd5; tick();
    chk("wr_front_untouched", rd_data, 0);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("pend_set", swap_pending, 1);
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    chk("swap2_front", front_sel, 1);
    chk("swap2_pend", swap_pending, 0);
    chk("swap2_rd_old_front", rd_data, 0);
    tick();
    chk("swap2_rd_new_front", rd_data, 4'hA);

    // One request, three VSYNCs: only the first toggles.
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vsync_start = 1'b1; tick(); vsync_start = 1'b0;
      chk("vs3_front", front_sel, 0);
    end
    chk("vs3_pend", swap_pending, 0);
    swap_req = 1'b1; vsync_start = 1'b1; tick(); swap_req = 1'b0; vsync_start = 1'b0;
    chk("coinc_no_toggle", front_sel, 0);
    chk("coinc_pend", swap_pending, 1);
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    chk("coinc_next_toggle", front_sel, 1);
    chk("coinc_pend_clr", swap_pending, 0);
    swap_req = 1'b1; tick();
    vsync_start = 1'b1; tick(); swap_req = 1'b0; vsync_start = 1'b0;
    chk("absorb_toggle", front_sel, 0);
    chk("absorb_pend", swap_pending, 0);
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    chk("absorb_no_second", front_sel, 0);

    // Boundary writes: last valid address lands, first invalid is dropped.
    wr_addr = 15'd19199; wr_data = 4'h9; wr_en = 1'b1; tick();
    wr_addr = 15'd19200; wr_data = 4'h7; tick(); wr_en = 1'b0;
    rd_addr = 15'd20000; tick();
    chk("oor_rd_20000", rd_data, 0);
`ifdef FB_OOR_COUNT_EN
    chk("oor_cnt_one", oor_cnt, 1);
`endif
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    chk("bnd_front", front_sel, 1);
    rd_addr = 15'd19199; tick();
    chk("bnd_rd_last", rd_data, 4'h9);
    rd_addr = 15'd19200; tick();
    chk("bnd_rd_first_oor", rd_data, 0);
    rd_addr = 15'd32767; tick();
    chk("bnd_rd_max", rd_data, 0);

    // Asynchronous reset 500 cycles into a clear, with a swap pending.
    rd_addr = 15'd5;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (498) tick();
    chk("prerst_busy", busy, 1);
    chk("prerst_pend", swap_pending, 1);
    chk("prerst_front", front_sel, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", wr_ready, 1);
    chk("arst_front", front_sel, 0);
    chk("arst_pend", swap_pending, 0);
    chk("arst_rd", rd_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    run_clear(1'b0, -1, -1, nb, nr);
    chk("restart_busy_len", nb, DEPTH);
    chk("restart_notready_len", nr, DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
